// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory handshake: FSM states, op encoding and
// the default access latency used by both the memory and its users.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  localparam int unsigned MEM_LATENCY = 5;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned MEM_CNT_WIDTH = 4;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter that times the ACCESS phase of a data-memory transaction.
module dmem_wait_counter
  import cpu_mem_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LOAD,
  input  logic [MEM_CNT_WIDTH-1:0] LOAD_VALUE,
  output logic                     ZERO
);

  logic [MEM_CNT_WIDTH-1:0] cnt_q;

  // Saturates at zero, so it idles quietly between accesses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (LOAD) begin
      cnt_q <= LOAD_VALUE;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory with a fixed-latency BUSYWAIT handshake toward the CPU.
// Requests are latched on acceptance; the result is held for one DONE cycle.
module data_memory
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LATENCY    = MEM_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  op_q;
  logic                  accept;
  logic                  complete;
  logic                  cnt_zero;
  logic [DATA_WIDTH-1:0] mem [Depth];

  dmem_wait_counter u_wait_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .LOAD       (accept),
    .LOAD_VALUE (MEM_CNT_WIDTH'(LATENCY - 1)),
    .ZERO       (cnt_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    BUSYWAIT = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        BUSYWAIT = (READ | WRITE) & ~RESET;
        if (READ | WRITE) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        BUSYWAIT = ~RESET;
        if (cnt_zero) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read wins when both strobes are high.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= ADDRESS;
      wdata_q <= WRITEDATA;
      op_q    <= READ ? MEM_OP_READ : MEM_OP_WRITE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      READDATA <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else if (complete) begin
      if (op_q == MEM_OP_WRITE) begin
        mem[addr_q] <= wdata_q;
      end else begin
        READDATA <= mem[addr_q];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: handshake timing, read/write data, reset abort.
module tb_data_memory;
  import cpu_mem_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  int n_checks;
  int n_fail;

  localparam int StallCycles = MEM_LATENCY + 1;

  data_memory #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .LATENCY    (MEM_LATENCY)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts stall cycles from the current cycle until BUSYWAIT drops (bounded).
  task automatic wait_done(output int busy);
    busy = 0;
    while (BUSYWAIT === 1'b1 && busy < 40) begin
      busy++;
      tick();
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, output int busy,
                           output logic [7:0] rdata);
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = data;
    #1;
    wait_done(busy);
    rdata = READDATA;
    READ  = 1'b0;
    WRITE = 1'b0;
    tick();
  endtask

  initial begin
    int         busy;
    int         busy2;
    logic [7:0] rdata;

    n_checks  = 0;
    n_fail    = 0;
    RESET     = 1'b1;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 8'h00;
    WRITEDATA = 8'h00;
    tick();
    tick();
    check("reset_readdata", 32'(READDATA), 32'h00);
    check("reset_busy_idle", 32'(BUSYWAIT), 32'h0);
    READ = 1'b1;
    #1;
    check("busy_masked_by_reset", 32'(BUSYWAIT), 32'h0);
    READ  = 1'b0;
    RESET = 1'b0;
    tick();

    // Read of a cleared location
    do_access(1'b1, 1'b0, 8'h10, 8'h00, busy, rdata);
    check("rd10_stall", 32'(busy), 32'(StallCycles));
    check("rd10_data", 32'(rdata), 32'h00);
    check("idle_after_rd10", 32'(BUSYWAIT), 32'h0);

    // Write then read back; the write must not disturb READDATA
    do_access(1'b0, 1'b1, 8'h3C, 8'hA5, busy, rdata);
    check("wr3c_stall", 32'(busy), 32'(StallCycles));
    check("wr3c_readdata_kept", 32'(rdata), 32'h00);
    do_access(1'b1, 1'b0, 8'h3C, 8'h00, busy, rdata);
    check("rd3c_stall", 32'(busy), 32'(StallCycles));
    check("rd3c_data", 32'(rdata), 32'hA5);

    // Both strobes high: a read, nothing stored
    do_access(1'b1, 1'b1, 8'h05, 8'h77, busy, rdata);
    check("both_stall", 32'(busy), 32'(StallCycles));
    check("both_is_read", 32'(rdata), 32'h00);
    do_access(1'b1, 1'b0, 8'h05, 8'h00, busy, rdata);
    check("rd05_no_write", 32'(rdata), 32'h00);

    // Request held through DONE: second access starts only from IDLE
    READ    = 1'b1;
    ADDRESS = 8'h3C;
    #1;
    wait_done(busy);
    check("held_first_stall", 32'(busy), 32'(StallCycles));
    check("held_first_data", 32'(READDATA), 32'hA5);
    tick();
    wait_done(busy2);
    check("held_second_stall", 32'(busy2), 32'(StallCycles));
    check("held_second_data", 32'(READDATA), 32'hA5);
    READ = 1'b0;
    tick();
    check("held_idle_after", 32'(BUSYWAIT), 32'h0);

    // Inputs changed mid-ACCESS are ignored
    WRITE     = 1'b1;
    ADDRESS   = 8'h01;
    WRITEDATA = 8'h11;
    tick();
    ADDRESS   = 8'h02;
    WRITEDATA = 8'hEE;
    #1;
    wait_done(busy);
    check("midchg_access_cycles", 32'(busy), 32'(MEM_LATENCY));
    WRITE = 1'b0;
    tick();
    do_access(1'b1, 1'b0, 8'h01, 8'h00, busy, rdata);
    check("midchg_latched_data", 32'(rdata), 32'h11);
    do_access(1'b1, 1'b0, 8'h02, 8'h00, busy, rdata);
    check("midchg_new_addr_untouched", 32'(rdata), 32'h00);

    // Put A5 in READDATA so reset clearing is visible
    do_access(1'b1, 1'b0, 8'h3C, 8'h00, busy, rdata);
    check("pre_reset_data", 32'(rdata), 32'hA5);

    // Reset in the 3rd ACCESS cycle aborts the write
    WRITE     = 1'b1;
    ADDRESS   = 8'h20;
    WRITEDATA = 8'h5A;
    tick();
    tick();
    tick();
    check("abort_busy_before_reset", 32'(BUSYWAIT), 32'h1);
    WRITE = 1'b0;
    RESET = 1'b1;
    #1;
    check("abort_busy_during_reset", 32'(BUSYWAIT), 32'h0);
    tick();
    RESET = 1'b0;
    #1;
    check("abort_busy_after_edge", 32'(BUSYWAIT), 32'h0);
    check("abort_readdata_cleared", 32'(READDATA), 32'h00);
    tick();
    check("abort_still_idle", 32'(BUSYWAIT), 32'h0);
    do_access(1'b1, 1'b0, 8'h20, 8'h00, busy, rdata);
    check("abort_rd20_stall", 32'(busy), 32'(StallCycles));
    check("abort_rd20_data", 32'(rdata), 32'h00);
    do_access(1'b1, 1'b0, 8'h3C, 8'h00, busy, rdata);
    check("reset_cleared_3c", 32'(rdata), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressed data memory that serves as the responder for the CPU's load and store accesses. The CPU is the initiator and drives READ or WRITE with ADDRESS and WRITEDATA. This block stalls the CPU through BUSYWAIT for a fixed, parameterised access latency. It then either commits the write or returns READDATA, holding the result for exactly one cycle with BUSYWAIT low.

## Interface
Parameters:
- ADDR_WIDTH, 8: address width; depth = 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8: word width; matches the register-file width.
- LATENCY, 5: number of ACCESS-state cycles; legal range is 1..15.

Ports:
- CLK  in  1  clock; all state changes on the posedge.
- RESET  in  1  reset; synchronous, active-high; clock CLK.
- READ  in  1  load request; level, held by the CPU until it sees BUSYWAIT low.
- WRITE  in  1  store request; level, same rule as READ.
- ADDRESS  in  ADDR_WIDTH  byte address.
- WRITEDATA  in  DATA_WIDTH  store data.
- READDATA  out  DATA_WIDTH  load result; registered.
- BUSYWAIT  out  1  stall request to the CPU.

## Operation
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - BUSYWAIT = (READ | WRITE) & ~RESET, combinational, so the CPU stalls in the same cycle it issues a request.
  - At the posedge with READ|WRITE: latch ADDRESS, WRITEDATA and the op; load the counter with LATENCY-1; go to ACCESS.
  - If READ and WRITE are both high, the access is a read; no write occurs.
- ACCESS:
  - BUSYWAIT = 1. The counter decrements each posedge.
  - At the posedge where the counter is 0:
    - Read: READDATA <= mem[latched addr].
    - Write: mem[latched addr] <= latched data.
    - Go to DONE.
  - Inputs are ignored during ACCESS; only latched values are used.
- DONE:
  - BUSYWAIT = 0 and READDATA is valid. Go to IDLE unconditionally at the next posedge.
  - A request still asserted in DONE is ignored. The CPU drops or replaces it at that edge.
- READDATA changes only on read completion or on RESET. A write leaves READDATA unchanged.
- RESET, at any state including mid-ACCESS:
  - State <= IDLE, counter <= 0, READDATA <= 0, every mem entry <= 0.
  - An in-flight write is discarded.
  - BUSYWAIT is 0 while RESET is high.
- Address arithmetic is modulo 2**ADDR_WIDTH. There are no out-of-range cases.

## Timing
- Request accepted at posedge T0, where the CPU asserted it in cycle T0-1.
- BUSYWAIT is high from cycle T0-1 through cycle T0+LATENCY-1, i.e. LATENCY+1 cycles.
- DONE occupies cycle T0+LATENCY: BUSYWAIT is low and READDATA is valid.
- The next request can be accepted at the posedge ending cycle T0+LATENCY+1, which is the first IDLE cycle. Back-to-back throughput is one access per LATENCY+2 cycles.
- LATENCY=1: ACCESS lasts exactly one cycle.
- Reset values: READDATA=0, BUSYWAIT=0, state=IDLE.

## Structure
- Shared package cpu_mem_pkg holds:
  - the state typedef: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - the op constants MEM_OP_READ and MEM_OP_WRITE;
  - the default LATENCY constant, so the CPU-side stall logic and the testbench use one value.
- One sub-module, dmem_wait_counter: a loadable down-counter with LOAD, LOAD_VALUE and ZERO outputs and synchronous clear on RESET. The FSM and storage array stay in data_memory.

## Test plan
All scenarios use LATENCY=5.
- Reset, then READ at 0x10: BUSYWAIT is high for 6 cycles and low in the 7th; READDATA=0x00 in the DONE cycle.
- WRITE 0xA5 to 0x3C, then READ 0x3C: READDATA stays 0x00 through the write and is 0xA5 in the read's DONE cycle.
- READ and WRITE both high with ADDRESS 0x05 and WRITEDATA 0x77: treated as a read; a later read of 0x05 returns 0x00.
- WRITE 0x5A to 0x20; assert RESET in the 3rd ACCESS cycle:
  - BUSYWAIT is 0 in the cycle after that edge;
  - a later read of 0x20 returns 0x00;
  - READDATA is 0x00.
- Request held high through DONE into IDLE (READ 0x3C): exactly two accesses occur, each with a 6-cycle stall; nothing is accepted in DONE.
- ADDRESS and WRITEDATA change mid-ACCESS: the write commits the values latched at acceptance (0x11 to 0x01), not the new inputs.
